// File: rtl/wb_cmd_master_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : wb_cmd_master_pkg                                        |
// | Brief   : Completion codes and FSM state type for wb_cmd_master.   |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package wb_cmd_master_pkg;

  localparam logic [1:0] C_STATUS_OK      = 2'b00;
  localparam logic [1:0] C_STATUS_ERR     = 2'b01;
  localparam logic [1:0] C_STATUS_RTY     = 2'b10;
  localparam logic [1:0] C_STATUS_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_RSP     = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : wb_cmd_master                                            |
// | Brief   : Single-beat command to Wishbone pipelined master with    |
// |           bounded retry and watchdog timeout.                      |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int G_ADDR_WIDTH = 32,
  parameter int G_DATA_WIDTH = 32,
  parameter int G_TIMEOUT    = 255,
  parameter int G_MAX_RETRY  = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [G_ADDR_WIDTH-1:0]   cmd_adr_i,
  input  logic [G_DATA_WIDTH/8-1:0] cmd_sel_i,
  input  logic [G_DATA_WIDTH-1:0]   cmd_dat_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [G_DATA_WIDTH-1:0]   rsp_dat_o,
  output logic [1:0]                rsp_status_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [G_ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [G_DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [G_DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [G_DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i,
  input  logic                      wb_rty_i,
  input  logic                      wb_stall_i
);

  localparam int TMO_W = $clog2(G_TIMEOUT + 1);
  localparam int RTY_W = (G_MAX_RETRY < 1) ? 1 : $clog2(G_MAX_RETRY + 1);

  state_t                  r_state;
  logic [TMO_W-1:0]        r_tmo_cnt;
  logic [RTY_W-1:0]        r_rty_cnt;

  logic                    w_tmo_hit;
  logic                    w_done;
  logic                    w_backoff;
  logic [1:0]              w_status;
  logic [G_DATA_WIDTH-1:0] w_rdat;

  // The edge that completes the G_TIMEOUT-th bus cycle is the abort edge.
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(G_TIMEOUT - 1));

  // Termination decode, priority err > rty > ack > watchdog.
  always_comb begin
    w_done    = 1'b1;
    w_backoff = 1'b0;
    w_status  = C_STATUS_OK;
    w_rdat    = '0;
    if (wb_err_i) begin
      w_status = C_STATUS_ERR;
    end else if (wb_rty_i) begin
      if (r_rty_cnt < RTY_W'(G_MAX_RETRY)) begin
        w_done    = 1'b0;
        w_backoff = 1'b1;
      end else begin
        w_status = C_STATUS_RTY;
      end
    end else if (wb_ack_i) begin
      w_rdat = wb_we_o ? '0 : wb_dat_i;
    end else if (w_tmo_hit) begin
      w_status = C_STATUS_TIMEOUT;
    end else begin
      w_done = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_tmo_cnt    <= '0;
      r_rty_cnt    <= '0;
      cmd_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= C_STATUS_OK;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_sel_o     <= '0;
      wb_dat_o     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            wb_we_o     <= cmd_we_i;
            wb_adr_o    <= cmd_adr_i;
            wb_sel_o    <= cmd_sel_i;
            wb_dat_o    <= cmd_dat_i;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            cmd_ready_o <= 1'b0;
            r_tmo_cnt   <= '0;
            r_rty_cnt   <= '0;
            r_state     <= ST_REQ;
          end
        end

        ST_REQ, ST_WAIT: begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          if (w_done) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= w_status;
            rsp_dat_o    <= w_rdat;
            r_state      <= ST_RSP;
          end else if (w_backoff) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            r_rty_cnt <= r_rty_cnt + RTY_W'(1);
            r_state   <= ST_BACKOFF;
          end else if (r_state == ST_REQ && !wb_stall_i) begin
            wb_stb_o <= 1'b0;
            r_state  <= ST_WAIT;
          end
        end

        ST_BACKOFF: begin
          wb_cyc_o  <= 1'b1;
          wb_stb_o  <= 1'b1;
          r_tmo_cnt <= '0;
          r_state   <= ST_REQ;
        end

        ST_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_wb_cmd_master                                         |
// | Brief   : Directed self-checking bench for wb_cmd_master.          |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_wb_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_adr_i = '0;
  logic [3:0]    cmd_sel_i = '0;
  logic [DW-1:0] cmd_dat_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_dat_o;
  logic [1:0]    rsp_status_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [3:0]    wb_sel_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_ack_i = 1'b0;
  logic          wb_err_i = 1'b0;
  logic          wb_rty_i = 1'b0;
  logic          wb_stall_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_stb;
  logic [DW-1:0] slv_reg;

  wb_cmd_master #(
    .G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW), .G_TIMEOUT(8), .G_MAX_RETRY(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command for exactly one accept edge.
  task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [3:0] sel,
                       input logic [DW-1:0] dat);
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_sel_i   = sel;
    cmd_dat_i   = dat;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic rsp_hs();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    // Reset state
    rst_i = 1'b1;
    tick();
    tick();
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'h1);
    chk("rst_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'h0);
    chk("rst_rsp", 64'({rsp_valid_o, rsp_status_o, rsp_dat_o}), 64'h0);
    chk("rst_adr_dat", 64'({wb_adr_o, wb_dat_o}), 64'h0);
    rst_i = 1'b0;
    tick();

    // Termination while idle is ignored
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("idle_ack_ignored", 64'({rsp_valid_o, cmd_ready_o, wb_cyc_o}), 64'b010);

    // Write 0xDEADBEEF to address 0
    issue(1'b1, 32'h0, 4'hF, 32'hDEAD_BEEF);
    chk("wr_req_ctrl", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, cmd_ready_o}), 64'b111_1111_0);
    chk("wr_req_dat", 64'({wb_adr_o, wb_dat_o}), 64'h0000_0000_DEAD_BEEF);
    tick();
    chk("wr_wait", 64'({wb_cyc_o, wb_stb_o}), 64'b10);
    slv_reg  = wb_dat_o;
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("wr_rsp", 64'({rsp_valid_o, rsp_status_o, rsp_dat_o, wb_cyc_o}), {29'h0, 1'b1, 2'b00, 32'h0, 1'b0});
    rsp_hs();
    chk("wr_rsp_done", 64'({rsp_valid_o, cmd_ready_o}), 64'b01);

    // Read back: accept T, stb accepted T+1, ack at T+2, rsp after T+2
    issue(1'b0, 32'h0, 4'hF, 32'h0);
    tick();
    wb_ack_i = 1'b1;
    wb_dat_i = slv_reg;
    tick();
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    chk("rd_rsp", 64'({rsp_valid_o, rsp_status_o, rsp_dat_o}), {29'h0, 1'b1, 2'b00, 32'hDEAD_BEEF});
    rsp_hs();

    // Read with 4 stalled edges: stb held 5 cycles, adr stable
    wb_stall_i = 1'b1;
    issue(1'b0, 32'h10, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_stb_adr", 64'({wb_stb_o, wb_adr_o}), {31'h0, 1'b1, 32'h10});
    end
    wb_stall_i = 1'b0;
    tick();
    chk("stall_released", 64'({wb_cyc_o, wb_stb_o}), 64'b10);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h1234_5678;
    tick();
    wb_ack_i = 1'b0;
    chk("stall_rsp", 64'({rsp_valid_o, rsp_status_o, rsp_dat_o}), {29'h0, 1'b1, 2'b00, 32'h1234_5678});
    rsp_hs();

    // Two retries then ack
    issue(1'b1, 32'h4, 4'h3, 32'h0000_A5A5);
    n_stb = 1;
    for (int r = 0; r < 2; r++) begin
      tick();
      wb_rty_i = 1'b1;
      tick();
      wb_rty_i = 1'b0;
      chk("rty_backoff", 64'({wb_cyc_o, wb_stb_o, rsp_valid_o}), 64'b000);
      tick();
      if (wb_stb_o) n_stb++;
      chk("rty_reissue", 64'({wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o[7:0], wb_dat_o}),
          {22'h0, 1'b1, 1'b1, 4'h3, 8'h04, 32'h0000_A5A5});
    end
    chk("rty_issue_count", 64'(n_stb), 64'd3);
    tick();
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("rty_then_ok", 64'({rsp_valid_o, rsp_status_o, rsp_dat_o}), {29'h0, 1'b1, 2'b00, 32'h0});
    rsp_hs();

    // Retry forever: 4 issues then RTY
    issue(1'b0, 32'h8, 4'hF, 32'h0);
    wb_rty_i = 1'b1;
    wb_dat_i = 32'hFFFF_FFFF;
    n_stb = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (wb_stb_o) n_stb++;
    end
    wb_rty_i = 1'b0;
    chk("rty_max_issues", 64'(n_stb), 64'd4);
    chk("rty_max_rsp", 64'({rsp_valid_o, rsp_status_o, rsp_dat_o}), {29'h0, 1'b1, 2'b10, 32'h0});
    rsp_hs();

    // Silent slave: abort after 8 bus cycles
    wb_dat_i = 32'h0000_CAFE;
    issue(1'b0, 32'hC, 4'hF, 32'h0);
    for (int i = 0; i < 7; i++) tick();
    chk("tmo_cyc_held", 64'({wb_cyc_o, rsp_valid_o}), 64'b10);
    tick();
    chk("tmo_rsp", 64'({wb_cyc_o, rsp_valid_o, rsp_status_o, rsp_dat_o}), {28'h0, 1'b0, 1'b1, 2'b11, 32'h0});
    rsp_hs();

    // Ack on the 8th edge beats the watchdog
    issue(1'b0, 32'hC, 4'hF, 32'h0);
    for (int i = 0; i < 7; i++) tick();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h5555_AAAA;
    tick();
    wb_ack_i = 1'b0;
    chk("tmo_edge_ack", 64'({rsp_valid_o, rsp_status_o, rsp_dat_o}), {29'h0, 1'b1, 2'b00, 32'h5555_AAAA});
    rsp_hs();

    // Ack in the same edge as the stb accept
    issue(1'b0, 32'h14, 4'hF, 32'h0);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0000_0042;
    tick();
    wb_ack_i = 1'b0;
    chk("req_edge_ack", 64'({wb_cyc_o, rsp_valid_o, rsp_status_o, rsp_dat_o}), {28'h0, 1'b0, 1'b1, 2'b00, 32'h42});
    rsp_hs();

    // err and ack together, then response back-pressure
    issue(1'b0, 32'h18, 4'hF, 32'h0);
    tick();
    wb_err_i = 1'b1;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0000_1111;
    tick();
    wb_err_i = 1'b0;
    wb_ack_i = 1'b0;
    chk("err_over_ack", 64'({rsp_valid_o, rsp_status_o, rsp_dat_o}), {29'h0, 1'b1, 2'b01, 32'h0});
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", 64'({rsp_valid_o, cmd_ready_o, wb_cyc_o, rsp_status_o, rsp_dat_o}),
          {27'h0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0});
    end
    cmd_valid_i = 1'b0;
    rsp_hs();
    chk("bp_release", 64'({rsp_valid_o, cmd_ready_o, wb_cyc_o}), 64'b010);

    // Asynchronous reset while waiting for termination
    issue(1'b0, 32'h1C, 4'hF, 32'h0);
    tick();
    chk("pre_rst_wait", 64'({wb_cyc_o, wb_stb_o}), 64'b10);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst", 64'({wb_cyc_o, wb_stb_o, rsp_valid_o}), 64'b000);
    #1;
    rst_i = 1'b0;
    tick();
    chk("post_rst", 64'({cmd_ready_o, wb_cyc_o, rsp_valid_o}), 64'b100);

    // Fresh command after reset completes normally
    issue(1'b1, 32'h20, 4'hF, 32'h0BAD_F00D);
    chk("post_rst_req", 64'({wb_cyc_o, wb_stb_o, wb_dat_o}), {30'h0, 2'b11, 32'h0BAD_F00D});
    tick();
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("post_rst_rsp", 64'({rsp_valid_o, rsp_status_o, rsp_dat_o}), {29'h0, 1'b1, 2'b00, 32'h0});
    rsp_hs();
    chk("post_rst_idle", 64'({rsp_valid_o, cmd_ready_o}), 64'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
